// File: rtl/ctrl_sequencer.sv
// Multi-cycle sequencer: fetch/decode/execute control for the ALU, register file and data memory.
// Opcodes: 0-7 ALU (ADD..XORR), 8 BEQ, 9 BNE, 10 BLT, 11 LDR, 12 STR, 13 HALT, 14-15 NOP.
module ctrl_sequencer #(
  parameter int unsigned IW    = 9,
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  output logic [PC_W-1:0]  PC,
  input  logic [IW-1:0]    Instr,
  output logic [3:0]       ALU_OP,
  input  logic             Zero,
  output logic [2:0]       RegAddr,
  output logic             RegWrEn,
  output logic             WbSel,
  output logic             MemReq,
  output logic             MemWr,
  input  logic             MemAck,
  output logic             Done,
  output logic [CNT_W-1:0] RetireCnt
);

  localparam logic [3:0] OpXorr = 4'd7;
  localparam logic [3:0] OpBeq  = 4'd8;
  localparam logic [3:0] OpBne  = 4'd9;
  localparam logic [3:0] OpBlt  = 4'd10;
  localparam logic [3:0] OpLdr  = 4'd11;
  localparam logic [3:0] OpStr  = 4'd12;
  localparam logic [3:0] OpHalt = 4'd13;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StDone
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   ir_q;

  logic [3:0]      dec_op;
  logic [3:0]      ir_op;
  logic            ir_is_branch;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_br;
  logic [CNT_W-1:0] cnt_sat;

  always_comb begin
    dec_op       = Instr[IW-1:IW-4];
    ir_op        = ir_q[IW-1:IW-4];
    ir_is_branch = (ir_op == OpBeq) || (ir_op == OpBne) || (ir_op == OpBlt);
    pc_inc       = PC + PC_W'(1);
    // Offset is a 5-bit two's-complement value; the sum wraps modulo 2^PC_W.
    pc_br        = PC + {{(PC_W-5){ir_q[4]}}, ir_q[4:0]};
    cnt_sat      = (RetireCnt == {CNT_W{1'b1}}) ? RetireCnt : RetireCnt + CNT_W'(1);
  end

  assign ALU_OP  = ir_op;
  assign RegAddr = ir_q[2:0];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      PC        <= '0;
      ir_q      <= '0;
      RetireCnt <= '0;
      RegWrEn   <= 1'b0;
      WbSel     <= 1'b0;
      MemReq    <= 1'b0;
      MemWr     <= 1'b0;
      Done      <= 1'b0;
    end else begin
      RegWrEn <= 1'b0;
      WbSel   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (Start) begin
            state_q   <= StFetch;
            PC        <= '0;
            RetireCnt <= '0;
          end
        end
        StFetch: state_q <= StDecode;
        StDecode: begin
          ir_q <= Instr;
          if ((dec_op == OpLdr) || (dec_op == OpStr)) begin
            state_q <= StMem;
            MemReq  <= 1'b1;
            MemWr   <= (dec_op == OpStr);
          end else if (dec_op == OpHalt) begin
            state_q   <= StDone;
            Done      <= 1'b1;
            RetireCnt <= cnt_sat;
          end else begin
            state_q <= StExec;
            RegWrEn <= (dec_op <= OpXorr);
          end
        end
        StExec: begin
          state_q   <= StFetch;
          RetireCnt <= cnt_sat;
          PC        <= (ir_is_branch && Zero) ? pc_br : pc_inc;
        end
        StMem: begin
          if (MemAck) begin
            MemReq <= 1'b0;
            MemWr  <= 1'b0;
            if (ir_op == OpStr) begin
              state_q   <= StFetch;
              PC        <= pc_inc;
              RetireCnt <= cnt_sat;
            end else begin
              state_q <= StWb;
              RegWrEn <= 1'b1;
              WbSel   <= 1'b1;
            end
          end
        end
        StWb: begin
          state_q   <= StFetch;
          PC        <= pc_inc;
          RetireCnt <= cnt_sat;
        end
        StDone: begin
          if (Start) begin
            state_q   <= StFetch;
            PC        <= '0;
            RetireCnt <= '0;
            Done      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed vector bench for ctrl_sequencer with a registered instruction ROM model.
// A second instance with a 3-bit retire counter shares all inputs to exercise saturation.
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] pc;
  logic [8:0] instr;
  logic [3:0] alu_op;
  logic       zero;
  logic [2:0] reg_addr;
  logic       reg_wr_en;
  logic       wb_sel;
  logic       mem_req;
  logic       mem_wr;
  logic       mem_ack;
  logic       done;
  logic [15:0] retire_cnt;

  logic [9:0] s_pc;
  logic [3:0] s_alu_op;
  logic [2:0] s_reg_addr;
  logic       s_reg_wr_en;
  logic       s_wb_sel;
  logic       s_mem_req;
  logic       s_mem_wr;
  logic       s_done;
  logic [2:0] s_retire_cnt;

  logic [8:0] rom [1024];

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) instr <= rom[pc];

  ctrl_sequencer dut (
    .Clk(clk), .Reset(rst_n), .Start(start), .PC(pc), .Instr(instr), .ALU_OP(alu_op),
    .Zero(zero), .RegAddr(reg_addr), .RegWrEn(reg_wr_en), .WbSel(wb_sel), .MemReq(mem_req),
    .MemWr(mem_wr), .MemAck(mem_ack), .Done(done), .RetireCnt(retire_cnt)
  );

  ctrl_sequencer #(.CNT_W(3)) dut_sat (
    .Clk(clk), .Reset(rst_n), .Start(start), .PC(s_pc), .Instr(instr), .ALU_OP(s_alu_op),
    .Zero(zero), .RegAddr(s_reg_addr), .RegWrEn(s_reg_wr_en), .WbSel(s_wb_sel),
    .MemReq(s_mem_req), .MemWr(s_mem_wr), .MemAck(mem_ack), .Done(s_done),
    .RetireCnt(s_retire_cnt)
  );

  typedef struct {
    int restart;
    int pc;
    int op;
    int opnd;
    int zero;
    int wait_n;
    int post;
    int next_pc;
    int wr;
    int wb;
    int req;
    int memwr;
    int regaddr;
    int retire;
    int done;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Entered at a negedge in IDLE or DONE; leaves at the negedge of the first FETCH cycle.
  task automatic restart();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("restart_pc", int'(pc), 0);
    check("restart_retire", int'(retire_cnt), 0);
    check("restart_done", int'(done), 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   wr_n, wb_n, req_n, memwr_n, ra;
    logic [3:0] op4;
    logic [4:0] opnd5;
    string tag;
    wr_n = 0; wb_n = 0; req_n = 0; memwr_n = 0; ra = -1;
    tag = $sformatf("v%0d", idx);
    if (v.restart != 0) restart();
    op4   = 4'(v.op);
    opnd5 = 5'(v.opnd);
    rom[v.pc] = {op4, opnd5};
    zero = v.zero[0];
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_alu_op"}, int'(alu_op), v.op);
    for (int c = 0; c < v.post; c++) begin
      if (reg_wr_en) begin
        wr_n++;
        ra = int'(reg_addr);
      end
      if (wb_sel) wb_n++;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (mem_wr) memwr_n++;
        if (req_n == v.wait_n) mem_ack = 1'b1;
        req_n++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    zero = 1'b0;
    check({tag, "_regwr_cycles"}, wr_n, v.wr);
    check({tag, "_wbsel_cycles"}, wb_n, v.wb);
    check({tag, "_memreq_cycles"}, req_n, v.req);
    check({tag, "_memwr_cycles"}, memwr_n, (v.memwr != 0) ? v.req : 0);
    if (v.wr != 0) check({tag, "_regaddr"}, ra, v.regaddr);
    check({tag, "_pc"}, int'(pc), v.next_pc);
    check({tag, "_retire"}, int'(retire_cnt), v.retire);
    check({tag, "_retire_sat"}, int'(s_retire_cnt), (v.retire > 7) ? 7 : v.retire);
    check({tag, "_done"}, int'(done), v.done);
  endtask

  initial begin
    // restart pc op opnd zero wait post next wr wb req memwr ra retire done
    vecs[0]  = '{1,    0,   0,  3, 0, 0, 1,    1, 1, 0, 0, 0, 3,  1, 0};
    vecs[1]  = '{0,    1,  13,  0, 0, 0, 0,    1, 0, 0, 0, 0, 0,  2, 1};
    vecs[2]  = '{1,    0,  10, 31, 1, 0, 1, 1023, 0, 0, 0, 0, 0,  1, 0};
    vecs[3]  = '{0, 1023,   0,  5, 0, 0, 1,    0, 1, 0, 0, 0, 5,  2, 0};
    vecs[4]  = '{0,    0,   8,  5, 1, 0, 1,    5, 0, 0, 0, 0, 0,  3, 0};
    vecs[5]  = '{0,    5,   8, 30, 0, 0, 1,    6, 0, 0, 0, 0, 0,  4, 0};
    vecs[6]  = '{0,    6,   9, 31, 1, 0, 1,    5, 0, 0, 0, 0, 0,  5, 0};
    vecs[7]  = '{0,    5,   8, 30, 1, 0, 1,    3, 0, 0, 0, 0, 0,  6, 0};
    vecs[8]  = '{0,    3,  11,  1, 0, 4, 6,    4, 1, 1, 5, 0, 1,  7, 0};
    vecs[9]  = '{0,    4,  12,  2, 0, 0, 1,    5, 0, 0, 1, 1, 0,  8, 0};
    vecs[10] = '{0,    5,  10, 28, 0, 0, 1,    6, 0, 0, 0, 0, 0,  9, 0};
    vecs[11] = '{0,    6,  15,  0, 1, 0, 1,    7, 0, 0, 0, 0, 0, 10, 0};
    vecs[12] = '{0,    7,   4,  7, 1, 0, 1,    8, 1, 0, 0, 0, 7, 11, 0};
    vecs[13] = '{0,    8,  13,  0, 0, 0, 0,    8, 0, 0, 0, 0, 0, 12, 1};
    vecs[14] = '{1,    0,   0,  0, 0, 0, 1,    1, 1, 0, 0, 0, 0,  1, 0};
    vecs[15] = '{0,    1,  10, 28, 1, 0, 1, 1021, 0, 0, 0, 0, 0,  2, 0};
    vecs[16] = '{0, 1021,  11,  4, 0, 0, 2, 1022, 1, 1, 1, 0, 4,  3, 0};
    vecs[17] = '{0, 1022,  12,  7, 0, 3, 4, 1023, 0, 0, 4, 1, 0,  4, 0};
    vecs[18] = '{0, 1023,  13,  0, 0, 0, 0, 1023, 0, 0, 0, 0, 0,  5, 1};

    for (int i = 0; i < 1024; i++) rom[i] = 9'h1e0;
    rst_n = 1'b0;
    start = 1'b0;
    zero = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", int'(pc), 0);
    check("rst_retire", int'(retire_cnt), 0);
    check("rst_regwr", int'(reg_wr_en), 0);
    check("rst_wbsel", int'(wb_sel), 0);
    check("rst_memreq", int'(mem_req), 0);
    check("rst_memwr", int'(mem_wr), 0);
    check("rst_done", int'(done), 0);
    check("rst_alu_op", int'(alu_op), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

    // Start while in EXEC must not restart the program.
    restart();
    rom[0] = {4'd0, 5'd2};
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("exec_regwr", int'(reg_wr_en), 1);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("exec_start_pc", int'(pc), 1);
    check("exec_start_retire", int'(retire_cnt), 1);

    // Asynchronous reset in the middle of a load.
    rom[1] = {4'd11, 5'd2};
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_mem_req", int'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_memreq", int'(mem_req), 0);
    check("arst_pc", int'(pc), 0);
    check("arst_retire", int'(retire_cnt), 0);
    check("arst_regwr", int'(reg_wr_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_memreq", int'(mem_req), 0);
    check("idle_regwr", int'(reg_wr_en), 0);
    check("idle_pc", int'(pc), 0);
    check("idle_retire", int'(retire_cnt), 0);

    restart();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("post_rst_regwr", int'(reg_wr_en), 1);
    @(posedge clk);
    @(negedge clk);
    check("post_rst_pc", int'(pc), 1);
    check("post_rst_retire", int'(retire_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
